// File: rtl/csa_accum_sequencer_if.sv
// csa_accum_sequencer_if: job control, operand stream and result handshake
// bundle for the carry-save accumulator sequencer.
interface csa_accum_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_ready;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             result_ready;

    modport master (
        output start, num_ops, op_valid, op_data, result_ready,
        input  op_ready, busy, result_valid, result
    );

    modport slave (
        input  start, num_ops, op_valid, op_data, result_ready,
        output op_ready, busy, result_valid, result
    );
endinterface

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: folds a counted operand stream into a redundant sum/carry
// pair through one 3:2 compressor row, then ripples the pair down to binary.
module csa_accum_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    csa_accum_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, c_q, c_d, res_q, res_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] maj, sc_and;

    assign maj    = (s_q & c_q) | (s_q & bus.op_data) | (c_q & bus.op_data);
    assign sc_and = s_q & c_q;

    assign bus.op_ready     = state_q == ACCUM;
    assign bus.busy         = state_q != IDLE;
    assign bus.result_valid = state_q == DONE;
    assign bus.result       = res_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        rem_d   = rem_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (bus.start) begin
                if (bus.num_ops != '0) begin
                    rem_d   = bus.num_ops;
                    s_d     = '0;
                    c_d     = '0;
                    state_d = ACCUM;
                end else begin
                    res_d   = '0;
                    state_d = DONE;
                end
            end
            ACCUM: if (bus.op_valid) begin
                s_d   = s_q ^ c_q ^ bus.op_data;
                c_d   = {maj[WIDTH-2:0], 1'b0};
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) state_d = RESOLVE;
            end
            RESOLVE: if (c_q == '0) begin
                res_d   = s_q;
                state_d = DONE;
            end else begin
                s_d = s_q ^ c_q;
                c_d = {sc_and[WIDTH-2:0], 1'b0};
            end
            DONE: if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb_csa_accum_sequencer: directed and random jobs checked against a plain
// running-sum model, including the S+C invariant on every busy cycle.
module tb_csa_accum_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   accepts;
    logic [15:0] model_sum;
    logic [15:0] ops [16];
    int   rcyc;

    always #5 clk = ~clk;

    csa_accum_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus ();
    csa_accum_sequencer #(.WIDTH(16), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic [15:0] d;
        logic [15:0] inv;
        acc = bus.op_valid && bus.op_ready;
        d   = bus.op_data;
        @(posedge clk);
        #1;
        if (acc) begin
            model_sum += d;
            accepts++;
        end
        if (bus.busy && !bus.result_valid) begin
            inv = dut.s_q + dut.c_q;
            check("s_plus_c", 32'(inv), 32'(model_sum));
        end
    endtask

    // vmode: 0 back-to-back, 1 alternate cycles, 2 random gaps
    task automatic run_job(input int n, input int vmode, input int rhold, input bit poke, output int rc);
        logic [15:0] expected;
        int guard;
        expected = '0;
        for (int i = 0; i < n; i++) expected += ops[i];
        bus.start   = 1'b1;
        bus.num_ops = 4'(n);
        model_sum   = '0;
        accepts     = 0;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
        guard = 0;
        while (accepts < n && guard < 200) begin
            bus.op_valid = (vmode == 0) || (vmode == 1 && guard[0] == 1'b0) ||
                           (vmode == 2 && $urandom_range(0, 2) != 0);
            bus.op_data  = ops[accepts < 16 ? accepts : 0];
            tick();
            guard++;
        end
        bus.op_valid = 1'b0;
        bus.op_data  = 16'hDEAD;
        check("accepts", 32'(accepts), 32'(n));
        rc = 0;
        while (!bus.result_valid && rc < 40) begin
            check("op_ready_resolve", 32'(bus.op_ready), 0);
            tick();
            rc++;
        end
        check("result_valid", 32'(bus.result_valid), 1);
        check("result", 32'(bus.result), 32'(expected));
        check("op_ready_done", 32'(bus.op_ready), 0);
        for (int k = 0; k < rhold; k++) begin
            bus.start = poke;
            tick();
            check("hold_valid", 32'(bus.result_valid), 1);
            check("hold_result", 32'(bus.result), 32'(expected));
            check("hold_busy", 32'(bus.busy), 1);
        end
        bus.start        = poke;
        bus.result_ready = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        check("valid_drop", 32'(bus.result_valid), 0);
        check("busy_drop", 32'(bus.busy), 0);
        tick();
        check("still_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.num_ops      = '0;
        bus.op_valid     = 1'b0;
        bus.op_data      = '0;
        bus.result_ready = 1'b0;
        model_sum        = '0;
        accepts          = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.result_valid), 0);
        check("rst_ready", 32'(bus.op_ready), 0);
        check("rst_result", 32'(bus.result), 0);
        rst_n = 1'b1;
        tick();

        ops[0] = 16'h0001; ops[1] = 16'h0002; ops[2] = 16'h0003;
        run_job(3, 0, 0, 1'b0, rcyc);
        check("rcyc_small", 32'(rcyc), 2);

        ops[0] = 16'hFFFF; ops[1] = 16'h0001;
        run_job(2, 0, 0, 1'b0, rcyc);
        check("rcyc_wrap", 32'(rcyc), 16);

        run_job(0, 0, 1, 1'b0, rcyc);
        check("rcyc_zero", 32'(rcyc), 0);

        for (int i = 0; i < 15; i++) ops[i] = 16'h1111;
        run_job(15, 1, 5, 1'b1, rcyc);

        bus.start   = 1'b1;
        bus.num_ops = 4'd4;
        model_sum   = '0;
        accepts     = 0;
        tick();
        bus.start    = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_data  = 16'h5555;
        tick();
        bus.op_data  = 16'hAAAA;
        tick();
        bus.op_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.op_ready), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_valid", 32'(bus.result_valid), 0);
        check("abort_result", 32'(bus.result), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        ops[0] = 16'h1234;
        run_job(1, 0, 0, 1'b0, rcyc);

        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) ops[i] = 16'($urandom);
            run_job(n, 2, $urandom_range(0, 3), 1'b0, rcyc);
            check("rcyc_bound", 32'(rcyc <= 17), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csa_accum_sequencer.md
Name: csa_accum_sequencer

Overview:
Multi-operand accumulator controller for the 16-bit carry-save adder row used by the Wallace pipeline. It accepts a programmed number of operands over a valid/ready stream and folds each one into a redundant sum/carry pair with a per-bit 3:2 compressor row. It then resolves the pair to a binary result by iterating the same row with a zero third input. The result is offered on a valid/ready output. The block serves as the sequencing front-end for iterative, multi-cycle reductions that share one compressor row.

Parameters:
WIDTH, 16, datapath width of operands, sum/carry registers and result
CNT_W, 4, width of num_ops; up to 2^CNT_W-1 operands per job

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  job start pulse; sampled only in IDLE
num_ops  input  CNT_W  operand count for the job, latched on accepted start
op_valid  input  1  operand present on op_data
op_data  input  WIDTH  operand value
op_ready  output  1  block accepts an operand this cycle
busy  output  1  high whenever state != IDLE
result_valid  output  1  result available
result  output  WIDTH  accumulated sum, modulo 2^WIDTH
result_ready  input  1  consumer takes the result

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE, clears S, C, remaining counter and result to 0, and drives op_ready, busy and result_valid to 0. Reset asserted mid-job aborts the job with no partial result.
- State IDLE: op_ready=0, result_valid=0.
  - start with num_ops>0: latch remaining=num_ops, clear S=0 and C=0, go to ACCUM.
  - start with num_ops=0: result<=0, go to DONE.
- State ACCUM: op_ready=1. Each cycle with op_valid&op_ready:
  - S <= S ^ C ^ op_data.
  - C <= {maj(S,C,op_data)[WIDTH-2:0], 1'b0}; the MSB carry is dropped (modulo arithmetic).
  - remaining <= remaining-1.
  - When the accepted operand is the last one (remaining==1), go to RESOLVE in the same edge.
  - Idle cycles with op_valid=0 leave all state unchanged.
- State RESOLVE: op_ready=0. Each cycle:
  - if C==0: result <= S, go to DONE.
  - else: S <= S ^ C, C <= {(S & C)[WIDTH-2:0], 1'b0}.
  - Terminates within WIDTH+1 cycles in all cases.
- State DONE: result_valid=1 and result is held stable. When result_ready=1, go to IDLE; result_valid drops on the following cycle.
- busy=1 in ACCUM, RESOLVE and DONE.
- start is ignored outside IDLE. start and result_ready asserted in the same DONE cycle: start is ignored; the new job needs a start in IDLE.
- Latency from start (all operands presented back-to-back): 1 cycle to ACCUM, N cycles of accepts, then k+1 RESOLVE cycles, where k is the number of nonzero-carry iterations. result_valid rises on the next edge.
- op_data is never sampled outside ACCUM. op_valid high in other states has no effect.
- Arithmetic invariant, checkable every cycle in ACCUM and RESOLVE: (S + C) mod 2^WIDTH equals the sum of accepted operands mod 2^WIDTH.

Test Plan:
- num_ops=3, operands 0x0001, 0x0002, 0x0003 back-to-back -> result=0x0006, result_valid asserted; op_ready high for exactly 3 accepts.
- num_ops=2, operands 0xFFFF, 0x0001 -> result=0x0000 (wrap). RESOLVE runs 15 update cycles plus 1 detect cycle before DONE.
- num_ops=0 with start -> DONE on the next edge, result=0x0000, op_ready never asserted.
- num_ops=15, each operand 0x1111, with op_valid deasserted every other cycle; result_ready held low for 5 cycles in DONE -> result=0xFFFF held stable. A start pulse during DONE is ignored, and busy stays 1 until the handshake completes.
- rst_n pulsed low after 2 of 4 operands -> op_ready, busy and result_valid drop immediately (asynchronously). A following job with num_ops=1 and operand 0x1234 returns result=0x1234 with no residue from the aborted job.
- Random jobs (random num_ops 1..15, random operands, random op_valid/result_ready gaps) -> result equals the software sum mod 2^16, and the S+C invariant holds every cycle.
